// File: rtl/wb_statis_roi.sv
// rtl/wb_statis_roi.sv - white-balance ROI statistics, per-Bayer-colour sums/counts published on interrupt edge
// Optional saturating accumulators: define WB_STATIS_SAT_EN.
module wb_statis_roi #(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int WB_STATIS_WIDTH  = 29,
    parameter int WB_CNT_WIDTH     = 24,
    parameter int ROI_WD           = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   i_fval,
    input  logic                                   i_lval,
    input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    input  logic [1:0]                             iv_bayer_mode,
    input  logic [ROI_WD-1:0]                      iv_roi_offset_x,
    input  logic [ROI_WD-1:0]                      iv_roi_width,
    input  logic [ROI_WD-1:0]                      iv_roi_offset_y,
    input  logic [ROI_WD-1:0]                      iv_roi_height,
    input  logic                                   i_interrupt_pin,
    output logic [WB_STATIS_WIDTH-1:0]             ov_wb_statis_r,
    output logic [WB_STATIS_WIDTH-1:0]             ov_wb_statis_g,
    output logic [WB_STATIS_WIDTH-1:0]             ov_wb_statis_b,
    output logic [WB_CNT_WIDTH-1:0]                ov_wb_cnt_r,
    output logic [WB_CNT_WIDTH-1:0]                ov_wb_cnt_g,
    output logic [WB_CNT_WIDTH-1:0]                ov_wb_cnt_b,
    output logic                                   o_statis_valid
);
    localparam int CH = CHANNEL_NUM;
    localparam int DW = SENSOR_DAT_WIDTH;
    localparam int WS = WB_STATIS_WIDTH;
    localparam int WC = WB_CNT_WIDTH;
    localparam int LW = $clog2(CH + 1);
    localparam int SW = 8 + LW;
`ifdef WB_STATIS_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, LATCH} state_t;
    state_t state_q, state_d;
    logic [1:0] flush_q;

    logic fval_d, lval_d, int_d;
    logic fval_rise, fval_fall, lval_rise, lval_fall, int_rise;
    assign fval_rise = i_fval & ~fval_d;
    assign fval_fall = ~i_fval & fval_d;
    assign lval_rise = i_lval & ~lval_d;
    assign lval_fall = ~i_lval & lval_d;
    assign int_rise  = i_interrupt_pin & ~int_d;

    logic [1:0]        mode_s;
    logic [ROI_WD-1:0] ox_s, w_s, oy_s, h_s, y_q, c_q, c_cur;
    assign c_cur = lval_rise ? '0 : c_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fval_d <= 1'b0; lval_d <= 1'b0; int_d <= 1'b0;
            mode_s <= '0; ox_s <= '0; w_s <= '0; oy_s <= '0; h_s <= '0;
            y_q <= '0; c_q <= '0;
        end else begin
            fval_d <= i_fval; lval_d <= i_lval; int_d <= i_interrupt_pin;
            if (fval_rise) begin
                mode_s <= iv_bayer_mode;
                ox_s <= iv_roi_offset_x; w_s <= iv_roi_width;
                oy_s <= iv_roi_offset_y; h_s <= iv_roi_height;
            end
            if (fval_rise)      y_q <= '0;
            else if (lval_fall) y_q <= y_q + ROI_WD'(1);
            if (i_lval)         c_q <= c_cur + ROI_WD'(1);
        end
    end

    // ROI bounds evaluated one bit wider so offset+size never wraps
    logic [ROI_WD:0] x_end, y_end, lane_x [CH];
    logic            y_in;
    logic [CH-1:0]   lane_in;
    logic [1:0]      lane_idx [CH];
    assign x_end = {1'b0, ox_s} + {1'b0, w_s};
    assign y_end = {1'b0, oy_s} + {1'b0, h_s};
    assign y_in  = ({1'b0, y_q} >= {1'b0, oy_s}) && ({1'b0, y_q} < y_end);

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            lane_x[i]   = (ROI_WD+1)'(c_cur) * (ROI_WD+1)'(CH) + (ROI_WD+1)'(i);
            lane_in[i]  = i_lval && y_in && (lane_x[i] >= {1'b0, ox_s}) && (lane_x[i] < x_end);
            lane_idx[i] = {y_q[0], lane_x[i][0]} ^ mode_s;
        end
    end

    logic [7:0]    s1_dat [CH];
    logic [1:0]    s1_idx [CH];
    logic [CH-1:0] s1_in;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_in <= '0;
            for (int i = 0; i < CH; i++) begin s1_dat[i] <= '0; s1_idx[i] <= '0; end
        end else begin
            s1_in <= lane_in;
            for (int i = 0; i < CH; i++) begin
                s1_dat[i] <= iv_pix_data[i*DW+DW-1 -: 8];
                s1_idx[i] <= lane_idx[i];
            end
        end
    end

    logic [SW-1:0] ls_r, ls_g, ls_b, s2_r, s2_g, s2_b;
    logic [LW-1:0] lc_r, lc_g, lc_b, s2_cr, s2_cg, s2_cb;
    always_comb begin
        ls_r = '0; ls_g = '0; ls_b = '0; lc_r = '0; lc_g = '0; lc_b = '0;
        for (int i = 0; i < CH; i++) begin
            if (s1_in[i]) begin
                case (s1_idx[i])
                    2'd0:    begin ls_r = ls_r + SW'(s1_dat[i]); lc_r = lc_r + LW'(1); end
                    2'd3:    begin ls_b = ls_b + SW'(s1_dat[i]); lc_b = lc_b + LW'(1); end
                    default: begin ls_g = ls_g + SW'(s1_dat[i]); lc_g = lc_g + LW'(1); end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_r <= '0; s2_g <= '0; s2_b <= '0; s2_cr <= '0; s2_cg <= '0; s2_cb <= '0;
        end else begin
            s2_r <= ls_r; s2_g <= ls_g; s2_b <= ls_b; s2_cr <= lc_r; s2_cg <= lc_g; s2_cb <= lc_b;
        end
    end

    // G carries one extra bit because it sees twice the pixels; it is halved on latch
    logic [WS-1:0] acc_r, acc_b;
    logic [WS:0]   acc_g, sum_r, sum_b;
    logic [WS+1:0] sum_g;
    logic [WC-1:0] cnt_r, cnt_b;
    logic [WC:0]   cnt_g, sum_cr, sum_cb;
    logic [WC+1:0] sum_cg;
    assign sum_r  = {1'b0, acc_r} + (WS+1)'(s2_r);
    assign sum_b  = {1'b0, acc_b} + (WS+1)'(s2_b);
    assign sum_g  = {1'b0, acc_g} + (WS+2)'(s2_g);
    assign sum_cr = {1'b0, cnt_r} + (WC+1)'(s2_cr);
    assign sum_cb = {1'b0, cnt_b} + (WC+1)'(s2_cb);
    assign sum_cg = {1'b0, cnt_g} + (WC+2)'(s2_cg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0; acc_g <= '0; acc_b <= '0; cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
        end else if (fval_rise) begin
            acc_r <= '0; acc_g <= '0; acc_b <= '0; cnt_r <= '0; cnt_g <= '0; cnt_b <= '0;
        end else begin
            acc_r <= (SAT_EN && sum_r[WS])    ? '1 : sum_r[WS-1:0];
            acc_b <= (SAT_EN && sum_b[WS])    ? '1 : sum_b[WS-1:0];
            acc_g <= (SAT_EN && sum_g[WS+1])  ? '1 : sum_g[WS:0];
            cnt_r <= (SAT_EN && sum_cr[WC])   ? '1 : sum_cr[WC-1:0];
            cnt_b <= (SAT_EN && sum_cb[WC])   ? '1 : sum_cb[WC-1:0];
            cnt_g <= (SAT_EN && sum_cg[WC+1]) ? '1 : sum_cg[WC:0];
        end
    end

    logic do_latch;
    always_comb begin
        state_d  = state_q;
        do_latch = 1'b0;
        case (state_q)
            IDLE:  if (fval_rise) state_d = ACCUM;
            ACCUM: if (fval_fall) state_d = FLUSH;
            FLUSH: if (fval_rise) state_d = ACCUM;
                   else if (flush_q == 2'd2) state_d = LATCH;
            LATCH: begin
                do_latch = 1'b1;
                state_d  = fval_rise ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE; flush_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_q == FLUSH) ? flush_q + 2'd1 : 2'd0;
        end
    end

    logic [WS-1:0] hold_r, hold_g, hold_b, src_r, src_g, src_b;
    logic [WC-1:0] hold_cr, hold_cg, hold_cb, src_cr, src_cg, src_cb;
    logic          hold_valid;
    assign src_r  = do_latch ? acc_r        : hold_r;
    assign src_g  = do_latch ? acc_g[WS:1]  : hold_g;
    assign src_b  = do_latch ? acc_b        : hold_b;
    assign src_cr = do_latch ? cnt_r        : hold_cr;
    assign src_cg = do_latch ? cnt_g[WC:1]  : hold_cg;
    assign src_cb = do_latch ? cnt_b        : hold_cb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r <= '0; hold_g <= '0; hold_b <= '0; hold_cr <= '0; hold_cg <= '0; hold_cb <= '0;
            hold_valid <= 1'b0; o_statis_valid <= 1'b0;
            ov_wb_statis_r <= '0; ov_wb_statis_g <= '0; ov_wb_statis_b <= '0;
            ov_wb_cnt_r <= '0; ov_wb_cnt_g <= '0; ov_wb_cnt_b <= '0;
        end else begin
            hold_r <= src_r; hold_g <= src_g; hold_b <= src_b;
            hold_cr <= src_cr; hold_cg <= src_cg; hold_cb <= src_cb;
            o_statis_valid <= 1'b0;
            if (int_rise && (hold_valid || do_latch)) begin
                ov_wb_statis_r <= src_r; ov_wb_statis_g <= src_g; ov_wb_statis_b <= src_b;
                ov_wb_cnt_r <= src_cr; ov_wb_cnt_g <= src_cg; ov_wb_cnt_b <= src_cb;
                o_statis_valid <= 1'b1;
                hold_valid     <= 1'b0;
            end else if (do_latch) begin
                hold_valid <= 1'b1;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iv_pix_data, acc_g[0], cnt_g[0]};
endmodule
